bcd2_seg_counter: RTL and testbench

Two-digit decimal (00-99) up/down counter with a programmable prescaler. Encodes both digits to seven-segment patterns and drives the 14-bit both7seg bus consumed by the downstream two-digit display multiplexer (tens on [13:7], ones on [6:0]). Sits directly upstream of that multiplexer in the display path.

---
 rtl/bcd_seg_pkg.sv | 16 +
 rtl/seg7_enc.sv | 14 +
 rtl/bcd2_seg_counter.sv | 104 ++++++++++
 tb/tb_bcd2_seg_counter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared seven-segment definitions for the two-digit BCD display path.
// Segment order is bit0=a .. bit6=g, active-high.
package bcd_seg_pkg;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return nibble <= 4'd9;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD digit to seven-segment encoder; non-BCD input blanks.
module seg7_enc
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd_valid(bcd)) seg = SEG_LUT[bcd];
  end

endmodule

// File: rtl/bcd2_seg_counter.sv
// Two-digit BCD up/down counter with prescaler and registered 7-seg output.
// both7seg lags digits by one clock.
module bcd2_seg_counter
  import bcd_seg_pkg::*;
#(
  parameter int unsigned DIV        = 160000,
  parameter int unsigned CBITS      = 18,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [7:0]  load_val,
  output logic [7:0]  digits,
  output logic [13:0] both7seg,
  output logic        carry,
  output logic        load_err
);

  localparam logic [CBITS-1:0] TERM = CBITS'(DIV - 1);
  localparam logic [13:0]      POL  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [13:0]      SEG_RESET = {SEG_LUT[0], SEG_LUT[0]} ^ POL;

  logic [CBITS-1:0] presc;
  logic             step;
  logic             load_ok;
  logic [3:0]       tens_n, ones_n;
  logic             wrap;
  logic [6:0]       seg_tens, seg_ones;

  assign step    = en && (presc == TERM);
  assign load_ok = bcd_valid(load_val[7:4]) && bcd_valid(load_val[3:0]);

  always_comb begin
    tens_n = digits[7:4];
    ones_n = digits[3:0];
    wrap   = 1'b0;
    if (up) begin
      if (digits[3:0] == 4'd9) begin
        ones_n = 4'd0;
        if (digits[7:4] == 4'd9) begin
          tens_n = 4'd0;
          wrap   = 1'b1;
        end else begin
          tens_n = digits[7:4] + 4'd1;
        end
      end else begin
        ones_n = digits[3:0] + 4'd1;
      end
    end else begin
      if (digits[3:0] == 4'd0) begin
        ones_n = 4'd9;
        if (digits[7:4] == 4'd0) begin
          tens_n = 4'd9;
          wrap   = 1'b1;
        end else begin
          tens_n = digits[7:4] - 4'd1;
        end
      end else begin
        ones_n = digits[3:0] - 4'd1;
      end
    end
  end

  // A rejected load still lets the prescaler run; only a valid load restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (load && load_ok) begin
      presc <= '0;
    end else if (en) begin
      presc <= step ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits   <= 8'h00;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) digits <= load_val;
        else         load_err <= 1'b1;
      end else if (step) begin
        digits <= {tens_n, ones_n};
        carry  <= wrap;
      end
    end
  end

  seg7_enc u_enc_tens (.bcd(digits[7:4]), .seg(seg_tens));
  seg7_enc u_enc_ones (.bcd(digits[3:0]), .seg(seg_ones));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) both7seg <= SEG_RESET;
    else     both7seg <= {seg_tens, seg_ones} ^ POL;
  end

endmodule

// File: tb/tb_bcd2_seg_counter.sv
// Scoreboard bench: two DUT builds (DIV=4 active-high, DIV=1 active-low)
// checked every cycle against an integer-valued reference model.
module tb_bcd2_seg_counter;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned DIV1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0]  digits0, digits1;
  logic [13:0] seg0, seg1;
  logic        carry0, carry1, lerr0, lerr1;

  always #5 clk = ~clk;

  bcd2_seg_counter #(.DIV(DIV0), .CBITS(18), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .digits(digits0), .both7seg(seg0), .carry(carry0), .load_err(lerr0));

  bcd2_seg_counter #(.DIV(DIV1), .CBITS(2), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .digits(digits1), .both7seg(seg1), .carry(carry1), .load_err(lerr1));

  typedef struct {
    logic [7:0]  d [2];
    logic [13:0] s [2];
    logic        c [2];
    logic        e [2];
  } exp_t;

  exp_t exp_q[$];
  int passed = 0;
  int total  = 0;

  // Reference model: counter value kept as an integer 0..99
  int mval [2];
  int mpresc [2];
  int divs [2] = '{DIV0, DIV1};
  int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  function automatic logic [13:0] enc(int v, int al);
    logic [13:0] r;
    r = 14'((seg_tab[v / 10] << 7) | seg_tab[v % 10]);
    return (al != 0) ? ~r : r;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mval[i] = 0;
      mpresc[i] = 0;
    end
  endtask

  task automatic cycle(logic e_i, logic u_i, logic l_i, logic [7:0] lv_i);
    exp_t x;
    int lt, lo;
    bit step, ok;
    @(negedge clk);
    en = e_i; up = u_i; load = l_i; load_val = lv_i;
    lt = int'(lv_i[7:4]);
    lo = int'(lv_i[3:0]);
    ok = (lt <= 9) && (lo <= 9);
    for (int i = 0; i < 2; i++) begin
      x.s[i] = enc(mval[i], i);
      x.c[i] = 1'b0;
      x.e[i] = 1'b0;
      step = e_i && (mpresc[i] == divs[i] - 1);
      if (e_i) mpresc[i] = step ? 0 : mpresc[i] + 1;
      if (l_i && ok) begin
        mval[i] = lt * 10 + lo;
        mpresc[i] = 0;
      end else if (l_i) begin
        x.e[i] = 1'b1;
      end else if (step) begin
        if (u_i) begin
          x.c[i] = (mval[i] == 99);
          mval[i] = (mval[i] + 1) % 100;
        end else begin
          x.c[i] = (mval[i] == 0);
          mval[i] = (mval[i] + 99) % 100;
        end
      end
      x.d[i] = to_bcd(mval[i]);
    end
    exp_q.push_back(x);
  endtask

  // Asynchronous reset between edges, checked immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_digits0", digits0, 8'h00);
    check("rst_seg0", seg0, 14'h1FBF);
    check("rst_carry0", carry0, 0);
    check("rst_lerr0", lerr0, 0);
    check("rst_digits1", digits1, 8'h00);
    check("rst_seg1", seg1, 14'h2040);
    check("rst_carry1", carry1, 0);
    model_reset();
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check("digits0", digits0, x.d[0]);
      check("seg0", seg0, x.s[0]);
      check("carry0", carry0, x.c[0]);
      check("lerr0", lerr0, x.e[0]);
      check("digits1", digits1, x.d[1]);
      check("seg1", seg1, x.s[1]);
      check("carry1", carry1, x.c[1]);
      check("lerr1", lerr1, x.e[1]);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // Count up from reset through several decades
    for (int i = 0; i < 60; i++) cycle(1, 1, 0, 8'h00);

    // Wrap both directions after loading 99
    cycle(1, 1, 1, 8'h99);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 8'h00);
    cycle(1, 1, 1, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 8'h00);

    // Loads coincident with steps, and rejected loads
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 8'h42);
    cycle(1, 1, 1, 8'h3A);
    cycle(1, 1, 0, 8'h00);
    cycle(1, 0, 1, 8'hA3);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 8'h00);

    // Freeze
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 8'h00);

    // Reset mid-count at presc=2, digits=57, then resume
    cycle(1, 1, 1, 8'h57);
    cycle(1, 1, 0, 8'h00);
    cycle(1, 1, 0, 8'h00);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic e_r, u_r, l_r;
      logic [7:0] v_r;
      e_r = ($urandom_range(0, 9) != 0);
      u_r = ($urandom_range(0, 3) != 0);
      l_r = ($urandom_range(0, 24) == 0);
      v_r = 8'($urandom_range(0, 255));
      cycle(e_r, u_r, l_r, v_r);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
